fifo_rw_ctrl: RTL and testbench

//  Traffic controller for the 8x256 single-clock FIFO: drives wrreq/data and rdreq.
//  Per round, fills the FIFO with an incrementing byte ramp, pauses, then drains it.

---
 rtl/fifo_rw_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fifo_rw_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rw_ctrl.sv
// Write/read traffic master for a single-clock FIFO: fills it with a byte ramp, pauses, drains it.
// Define FIFO_CHECK_EN to compare returned read data against the ramp (err / err_cnt).
module fifo_rw_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned USEDW_W   = 8,
    parameter int unsigned PAUSE_CYC = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    input  logic [USEDW_W-1:0] fifo_usedw,
    input  logic [DATA_W-1:0]  fifo_q,
    output logic               wr_req,
    output logic [DATA_W-1:0]  wr_data,
    output logic               rd_req,
    output logic               busy,
    output logic [15:0]        pass_cnt,
    output logic               err,
    output logic [7:0]         err_cnt
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned PAUSE_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEPTH);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYC - 1);

    typedef enum logic [2:0] {StIdle, StFill, StWaitW, StDrain, StWaitR, StFlush} state_e;

    state_e              r_state, w_state_d;
    logic                r_wr_req, w_wr_req_d;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_d;
    logic                r_rd_req, w_rd_req_d;
    logic [CNT_W-1:0]    r_wr_cnt, w_wr_cnt_d;
    logic [CNT_W-1:0]    r_rd_cnt, w_rd_cnt_d;
    logic [PAUSE_W-1:0]  r_pause, w_pause_d;
    logic [15:0]         r_pass_cnt;
    logic                w_pass_inc;

    // Usedw is status only; it never steers the sequencing.
    logic w_unused;
    assign w_unused = ^{fifo_usedw, fifo_q};

    // Counters hold the number of requests already issued, including the one being registered.
    always_comb begin
        w_state_d   = r_state;
        w_wr_req_d  = 1'b0;
        w_wr_data_d = r_wr_data;
        w_rd_req_d  = 1'b0;
        w_wr_cnt_d  = r_wr_cnt;
        w_rd_cnt_d  = r_rd_cnt;
        w_pause_d   = r_pause;
        w_pass_inc  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && fifo_empty) begin
                    w_state_d   = StFill;
                    w_wr_req_d  = 1'b1;
                    w_wr_data_d = '0;
                    w_wr_cnt_d  = CNT_W'(1);
                end else if (start) begin
                    w_state_d  = StFlush;
                    w_rd_req_d = 1'b1;
                end
            end
            StFill: begin
                if (fifo_full || (r_wr_cnt == CNT_LAST)) begin
                    w_state_d = StWaitW;
                    w_pause_d = '0;
                end else begin
                    w_wr_req_d  = 1'b1;
                    w_wr_data_d = DATA_W'(r_wr_cnt);
                    w_wr_cnt_d  = r_wr_cnt + CNT_W'(1);
                end
            end
            StWaitW: begin
                if (r_pause == PAUSE_LAST) begin
                    w_state_d  = StDrain;
                    w_rd_req_d = ~fifo_empty;
                    w_rd_cnt_d = fifo_empty ? '0 : CNT_W'(1);
                end else begin
                    w_pause_d = r_pause + PAUSE_W'(1);
                end
            end
            StDrain: begin
                if (fifo_empty || (r_rd_cnt == CNT_LAST)) begin
                    w_state_d = StWaitR;
                    w_pause_d = '0;
                end else begin
                    w_rd_req_d = 1'b1;
                    w_rd_cnt_d = r_rd_cnt + CNT_W'(1);
                end
            end
            StWaitR: begin
                if (r_pause == PAUSE_LAST) begin
                    w_pass_inc = 1'b1;
                    if (start) begin
                        w_state_d   = StFill;
                        w_wr_req_d  = 1'b1;
                        w_wr_data_d = '0;
                        w_wr_cnt_d  = CNT_W'(1);
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_pause_d = r_pause + PAUSE_W'(1);
                end
            end
            StFlush: begin
                if (fifo_empty) begin
                    w_state_d = StIdle;
                end else begin
                    w_rd_req_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= StIdle;
            r_wr_req   <= 1'b0;
            r_wr_data  <= '0;
            r_rd_req   <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pause    <= '0;
            r_pass_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_wr_req  <= w_wr_req_d;
            r_wr_data <= w_wr_data_d;
            r_rd_req  <= w_rd_req_d;
            r_wr_cnt  <= w_wr_cnt_d;
            r_rd_cnt  <= w_rd_cnt_d;
            r_pause   <= w_pause_d;
            if (w_pass_inc) begin
                r_pass_cnt <= r_pass_cnt + 16'd1;
            end
        end
    end

`ifdef FIFO_CHECK_EN
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_exp_cnt;
    logic              r_err;
    logic [7:0]        r_err_cnt;
    logic              w_chk_act;

    // Read data arrives one cycle after the registered request; flush data is never checked.
    assign w_chk_act = r_rd_vld && ((r_state == StDrain) || (r_state == StWaitR));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_vld  <= 1'b0;
            r_exp_cnt <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_rd_vld <= r_rd_req;
            if (r_state == StWaitW) begin
                r_exp_cnt <= '0;
            end else if (w_chk_act) begin
                r_exp_cnt <= r_exp_cnt + DATA_W'(1);
                if (fifo_q != r_exp_cnt) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    assign err     = 1'b0;
    assign err_cnt = 8'h00;
`endif

    assign wr_req   = r_wr_req;
    assign wr_data  = r_wr_data;
    assign rd_req   = r_rd_req;
    assign busy     = (r_state != StIdle);
    assign pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_fifo_rw_ctrl.sv
// Scoreboard bench for fifo_rw_ctrl against a behavioural 8x256 FIFO with registered flags.
// Honours FIFO_CHECK_EN to set the expected err / err_cnt after a corrupted drain.
module tb_fifo_rw_ctrl;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned USEDW_W   = 8;
    localparam int unsigned PAUSE_CYC = 4;
    localparam int          BUDGET    = 2000;
`ifdef FIFO_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start     = 1'b0;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_usedw, fifo_q;
    logic        wr_req, rd_req, busy, err;
    logic [7:0]  wr_data, err_cnt;
    logic [15:0] pass_cnt;

    fifo_rw_ctrl #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .USEDW_W   (USEDW_W),
        .PAUSE_CYC (PAUSE_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_usedw (fifo_usedw),
        .fifo_q     (fifo_q),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .busy       (busy),
        .pass_cnt   (pass_cnt),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO model: not touched by the DUT reset, flags follow the stored count.
    logic [7:0] fmem [256];
    logic [7:0] fwp      = 8'd0;
    logic [7:0] frp      = 8'd0;
    logic [7:0] fq       = 8'd0;
    int         fcnt     = 0;
    int         n_rd     = 0;
    int         flip_a   = -1;
    int         flip_b   = -1;
    logic       tb_wr    = 1'b0;
    logic [7:0] tb_wdata = 8'd0;
    logic       f_wr, f_rd;

    assign f_wr       = (wr_req || tb_wr) && (fcnt < 256);
    assign f_rd       = rd_req && (fcnt > 0);
    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = (fcnt == 256);
    assign fifo_usedw = fcnt[7:0];
    assign fifo_q     = fq;

    always @(posedge sys_clk) begin
        if (f_wr) begin
            fmem[fwp] <= tb_wr ? tb_wdata : wr_data;
            fwp       <= fwp + 8'd1;
        end
        if (f_rd) begin
            fq   <= fmem[frp] ^ (((n_rd == flip_a) || (n_rd == flip_b)) ? 8'h01 : 8'h00);
            frp  <= frp + 8'd1;
            n_rd <= n_rd + 1;
        end
        fcnt <= fcnt + int'(f_wr) - int'(f_rd);
    end

    typedef enum {SelBusy, SelPass, SelErr, SelErrCnt, SelWrReq, SelWrData, SelRdReq,
                  SelReads, SelGap, SelWrRun, SelRdRun, SelOverlap, SelFullWr, SelWrLeft} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        int unsigned exp;
    } chk_t;

    logic [7:0] exp_wr [$];
    chk_t       stq [$];
    int         rd_mark = 0;
    int         checks = 0;
    int         failures = 0;

    int cyc = 0, last_wr_cyc = 0, gap = 0, wr_run = 0, rd_run = 0;
    int last_wr_run = 0, last_rd_run = 0, n_overlap = 0, n_full_wr = 0;
    bit prev_rd = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned sel_val(input sel_e s);
        case (s)
            SelBusy:    return 32'(busy);
            SelPass:    return 32'(pass_cnt);
            SelErr:     return 32'(err);
            SelErrCnt:  return 32'(err_cnt);
            SelWrReq:   return 32'(wr_req);
            SelWrData:  return 32'(wr_data);
            SelRdReq:   return 32'(rd_req);
            SelReads:   return 32'(n_rd - rd_mark);
            SelGap:     return 32'(gap);
            SelWrRun:   return 32'(last_wr_run);
            SelRdRun:   return 32'(last_rd_run);
            SelOverlap: return 32'(n_overlap);
            SelFullWr:  return 32'(n_full_wr);
            SelWrLeft:  return 32'(exp_wr.size());
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: owns every comparison; pops write expectations and pending status checks.
    initial begin
        logic [7:0] e;
        chk_t       c;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (wr_req) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(wr_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_data", 32'(wr_data), 32'(e));
                end
            end
            if (wr_req && fifo_full) n_full_wr++;
            if (wr_req && rd_req) n_overlap++;
            if (wr_req) begin
                wr_run++;
                last_wr_cyc = cyc;
            end else if (wr_run != 0) begin
                last_wr_run = wr_run;
                wr_run = 0;
            end
            if (rd_req) begin
                if (!prev_rd) gap = cyc - last_wr_cyc;
                rd_run++;
            end else if (rd_run != 0) begin
                last_rd_run = rd_run;
                rd_run = 0;
            end
            prev_rd = rd_req;
            while (stq.size() > 0) begin
                c = stq.pop_front();
                chk(c.name, sel_val(c.sel), c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_chk(input string n, input sel_e s, input int unsigned e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        stq.push_back(c);
    endtask

    task automatic push_wr_round();
        for (int i = 0; i < int'(DEPTH); i++) exp_wr.push_back(8'(i));
    endtask

    task automatic wait_rd_req();
        for (int i = 0; i < BUDGET && !rd_req; i++) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < BUDGET && busy; i++) tick();
    endtask

    initial begin
        push_chk("rst_wr_req", SelWrReq, 0);
        push_chk("rst_wr_data", SelWrData, 0);
        push_chk("rst_rd_req", SelRdReq, 0);
        push_chk("rst_busy", SelBusy, 0);
        push_chk("rst_pass", SelPass, 0);
        push_chk("rst_err", SelErr, 0);
        push_chk("rst_err_cnt", SelErrCnt, 0);
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();

        // Three back-to-back rounds; start dropped during the third drain.
        for (int r = 0; r < 3; r++) push_wr_round();
        rd_mark = n_rd;
        start = 1'b1;
        for (int i = 0; i < BUDGET && pass_cnt != 16'd1; i++) tick();
        push_chk("t1_pass", SelPass, 1);
        push_chk("t1_reads", SelReads, 256);
        push_chk("t1_pause_gap", SelGap, PAUSE_CYC + 1);
        push_chk("t1_wr_run", SelWrRun, 256);
        push_chk("t1_rd_run", SelRdRun, 256);
        push_chk("t1_err", SelErr, 0);
        push_chk("t2_busy_next_round", SelBusy, 1);
        for (int i = 0; i < BUDGET && pass_cnt != 16'd2; i++) tick();
        push_chk("t2_pass2", SelPass, 2);
        tick();
        wait_rd_req();
        start = 1'b0;
        push_chk("t6_busy_drain", SelBusy, 1);
        wait_idle();
        push_chk("t6_pass", SelPass, 3);
        push_chk("t6_busy", SelBusy, 0);
        push_chk("t2_reads", SelReads, 768);
        push_chk("t2_wr_left", SelWrLeft, 0);
        push_chk("t2_overlap", SelOverlap, 0);
        repeat (10) tick();
        push_chk("t6_stay_idle", SelBusy, 0);
        push_chk("t6_pass_hold", SelPass, 3);

        // Preload stale words so the next start flushes first.
        for (int i = 0; i < 10; i++) begin
            tb_wr    = 1'b1;
            tb_wdata = 8'hA0 + 8'(i);
            tick();
        end
        tb_wr = 1'b0;
        tick();
        rd_mark = n_rd;
        push_wr_round();
        start = 1'b1;
        for (int i = 0; i < BUDGET && !wr_req; i++) tick();
        push_chk("t3_flush_reads", SelReads, 10);
        push_chk("t3_flush_no_pass", SelPass, 3);
        wait_rd_req();
        start = 1'b0;
        wait_idle();
        push_chk("t3_pass", SelPass, 4);
        push_chk("t3_reads", SelReads, 266);
        push_chk("t3_err", SelErr, 0);
        push_chk("t3_wr_run", SelWrRun, 256);
        push_chk("t3_rd_run", SelRdRun, 256);

        // Corrupt bit 0 of drain reads 5 and 200.
        flip_a = n_rd + 5;
        flip_b = n_rd + 200;
        push_wr_round();
        start = 1'b1;
        wait_rd_req();
        start = 1'b0;
        wait_idle();
        push_chk("t4_err", SelErr, CHK_EN ? 1 : 0);
        push_chk("t4_err_cnt", SelErrCnt, CHK_EN ? 2 : 0);
        push_chk("t4_pass", SelPass, 5);
        repeat (10) tick();
        push_chk("t4_err_sticky", SelErr, CHK_EN ? 1 : 0);
        push_chk("t4_err_cnt_hold", SelErrCnt, CHK_EN ? 2 : 0);
        flip_a = -1;
        flip_b = -1;

        // Reset while word 100 is on the bus.
        push_wr_round();
        start = 1'b1;
        for (int i = 0; i < BUDGET && fcnt != 100; i++) tick();
        sys_rst_n = 1'b0;
        start = 1'b0;
        exp_wr.delete();
        push_chk("t5_wr_req", SelWrReq, 0);
        push_chk("t5_wr_data", SelWrData, 0);
        push_chk("t5_rd_req", SelRdReq, 0);
        push_chk("t5_busy", SelBusy, 0);
        push_chk("t5_pass", SelPass, 0);
        push_chk("t5_err", SelErr, 0);
        push_chk("t5_err_cnt", SelErrCnt, 0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        rd_mark = n_rd;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_chk("t5_flush_busy", SelBusy, 1);
        wait_idle();
        push_chk("t5_flush_reads", SelReads, 100);
        push_chk("t5_flush_pass", SelPass, 0);
        tick();
        push_wr_round();
        rd_mark = n_rd;
        start = 1'b1;
        wait_rd_req();
        start = 1'b0;
        wait_idle();
        push_chk("t5_clean_pass", SelPass, 1);
        push_chk("t5_clean_reads", SelReads, 256);
        push_chk("t5_clean_err", SelErr, 0);
        push_chk("t5_clean_gap", SelGap, PAUSE_CYC + 1);
        push_chk("t5_clean_rd_run", SelRdRun, 256);

        push_chk("end_overlap", SelOverlap, 0);
        push_chk("end_write_on_full", SelFullWr, 0);
        push_chk("end_wr_left", SelWrLeft, 0);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
